fetch: RTL

- Instruction fetch stage, directly upstream of the issue stage.
- Owns the fetch PC and reads instructions from the instruction cache via a request/wait handshake.
- Buffers fetched words in a small flushable queue so the cache keeps streaming while issue stalls.
- Presents {bubble, insn, pc} to issue; redirects on jumps from later stages.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_if.sv | 10 +
 rtl/fetch_queue.sv | 45 ++++
 rtl/fetch.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH_ST_FETCH = 1'b0,
    FETCH_ST_DRAIN = 1'b1
  } fetch_state_t;

  // r15 reads as the instruction address plus two words
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } q_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction cache read port: request/wait handshake between fetch and icache.
interface fetch_if;
  logic [31:0] ic_rd_addr;
  logic        ic_rd_req;
  logic        ic_rd_wait;
  logic [31:0] ic_rd_data;

  modport master (output ic_rd_addr, ic_rd_req, input ic_rd_wait, ic_rd_data);
  modport slave  (input ic_rd_addr, ic_rd_req, output ic_rd_wait, ic_rd_data);
endinterface

// File: rtl/fetch_queue.sv
// Flushable prefetch FIFO of {pc, insn}; clear wins over push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic     clk,
  input  logic     Nrst,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  q_entry_t din,
  output q_entry_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  q_entry_t [QDEPTH-1:0] mem;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!Nrst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, streams from the icache into a
// prefetch queue, and redirects on jumps. FETCH_PERF_COUNTERS_EN adds perf counters.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic        stall,
  input  logic        jmp,
  input  logic [31:0] jmppc,
  fetch_if.master     cache,
  output logic        bubble,
  output logic [31:0] insn,
  output logic [31:0] pc
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);
  fetch_state_t state;
  logic [31:0]  fetch_pc, target, jtgt;
  logic         pend, req, accept, live, bypass, push, pop;
  logic         q_full, q_empty;
  q_entry_t     q_head, q_in;

  assign jtgt = jmppc & ~32'h3;

  // A request left waiting stays up until the cache answers, whatever the queue does
  always_comb begin
    req = 1'b0;
    if (Nrst) begin
      if (state == FETCH_ST_DRAIN || pend) req = 1'b1;
      else                                 req = ~q_full | (q_empty & ~stall);
    end
  end

  assign accept = req & ~cache.ic_rd_wait;
  assign live   = accept & (state == FETCH_ST_FETCH) & ~jmp;
  assign bypass = live & q_empty & ~stall;
  assign push   = live & ~bypass;
  assign pop    = ~jmp & ~stall & ~q_empty;
  assign q_in   = '{pc: fetch_pc + PC_READ_OFFSET, insn: cache.ic_rd_data};

  assign cache.ic_rd_req  = req;
  assign cache.ic_rd_addr = fetch_pc;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .Nrst  (Nrst),
    .clr   (jmp),
    .push  (push),
    .pop   (pop),
    .din   (q_in),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (!Nrst) begin
      state    <= FETCH_ST_FETCH;
      fetch_pc <= RESET_PC;
      target   <= '0;
      pend     <= 1'b0;
      bubble   <= 1'b1;
      insn     <= '0;
      pc       <= '0;
    end else begin
      pend <= (state == FETCH_ST_FETCH) & req & cache.ic_rd_wait & ~jmp;

      if (jmp) begin
        if (req & cache.ic_rd_wait) begin
          state  <= FETCH_ST_DRAIN;
          target <= jtgt;
        end else begin
          state    <= FETCH_ST_FETCH;
          fetch_pc <= jtgt;
        end
      end else if (state == FETCH_ST_DRAIN) begin
        if (accept) begin
          state    <= FETCH_ST_FETCH;
          fetch_pc <= target;
        end
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (jmp) begin
        bubble <= 1'b1;
      end else if (!stall) begin
        if (!q_empty) begin
          bubble <= 1'b0;
          insn   <= q_head.insn;
          pc     <= q_head.pc;
        end else if (bypass) begin
          bubble <= 1'b0;
          insn   <= cache.ic_rd_data;
          pc     <= fetch_pc + PC_READ_OFFSET;
        end else begin
          bubble <= 1'b1;
        end
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!Nrst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (live)            perf_fetched <= perf_fetched + 32'd1;
      if (bubble && !stall) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif
endmodule
